// File: rtl/micro_sequencer.sv
// Microprogram next-address sequencer: WIDTH-bit microaddress, DEPTH-entry subroutine stack,
// loop counter and opcode-driven conditional jump/call/return.
module micro_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       op,
    input  logic             cc,
    input  logic             ld_ar,
    input  logic             zero,
    input  logic             cin,
    output logic [WIDTH-1:0] yout,
    output logic             cout,
    output logic             full,
    output logic             empty,
    output logic             cnt_zero,
    output logic             stk_err
);

    localparam int unsigned SpW  = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OpCont  = 3'd0,
        OpCjmp  = 3'd1,
        OpCcall = 3'd2,
        OpCret  = 3'd3,
        OpLdcnt = 3'd4,
        OpLoop  = 3'd5,
        OpPush  = 3'd6,
        OpCjar  = 3'd7
    } op_e;

    op_e              op_sel;
    logic [WIDTH-1:0] pc_q, ar_q, cnt_q, cnt_d;
    logic [WIDTH-1:0] y, tos;
    logic [SpW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic             err_q, err_d;
    logic             push_req, push_en;
    logic             stk_full, stk_empty;

    assign op_sel    = op_e'(op);
    assign stk_full  = (sp_q == SpW'(DEPTH));
    assign stk_empty = (sp_q == '0);
    // Only consumed when the stack is non-empty, so the wrapped index at SP==0 is harmless.
    assign tos       = stack_q[IdxW'(sp_q - 1'b1)];

    always_comb begin
        y        = pc_q;
        cnt_d    = cnt_q;
        sp_d     = sp_q;
        err_d    = err_q;
        push_req = 1'b0;
        push_en  = 1'b0;
        if (zero) begin
            y     = '0;
            sp_d  = '0;
            err_d = 1'b0;
        end else begin
            unique case (op_sel)
                OpCont:  y = pc_q;
                OpCjmp:  if (cc) y = din;
                OpCcall: begin
                    if (cc) begin
                        y        = din;
                        push_req = 1'b1;
                    end
                end
                OpCret: begin
                    if (cc) begin
                        if (stk_empty) begin
                            err_d = 1'b1;
                        end else begin
                            y    = tos;
                            sp_d = sp_q - 1'b1;
                        end
                    end
                end
                OpLdcnt: cnt_d = din;
                OpLoop: begin
                    // Decision uses the pre-edge count; underflow substitutes PC for TOS.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        if (stk_empty) err_d = 1'b1;
                        else           y     = tos;
                    end else begin
                        if (stk_empty) err_d = 1'b1;
                        else           sp_d  = sp_q - 1'b1;
                    end
                end
                OpPush: begin
                    push_req = 1'b1;
                    if (cc) cnt_d = din;
                end
                OpCjar:  if (cc) y = ar_q;
                default: y = pc_q;
            endcase
            if (push_req) begin
                if (stk_full) begin
                    err_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + 1'b1;
                end
            end
        end
        if (reset) y = '0;
    end

    assign yout     = y;
    assign cout     = cin & (&y);
    assign full     = stk_full;
    assign empty    = stk_empty;
    assign cnt_zero = (cnt_q == '0);
    assign stk_err  = err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            ar_q  <= '0;
            cnt_q <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_q  <= y + WIDTH'(cin);
            cnt_q <= cnt_d;
            sp_q  <= sp_d;
            err_q <= err_d;
            if (ld_ar) ar_q <= din;
            // Return address is the pre-edge PC, never the branch target.
            if (push_en) stack_q[IdxW'(sp_q)] <= pc_q;
        end
    end

endmodule
